scnn_wt_stream_ctrl: RTL and testbench

Sequential scheduler that takes one 5x5 filter (25 x 16-bit weights), zero-run compresses it one element per cycle into a local pair buffer, and streams the compressed (weight, zero-run index) pairs to each of the 4 PEs that need the filter. Sits between the weight loader and the per-PE weight FIFOs in the 4-PE SCNN array. It is the shared, time-multiplexed replacement for per-PE combinational weight compression.

---
 rtl/scnn_wt_pkg.sv | 19 +
 rtl/scnn_rr_arbiter.sv | 40 ++++
 rtl/scnn_wt_stream_ctrl.sv | 152 +++++++++++++++
 tb/tb_scnn_wt_stream_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scnn_wt_pkg.sv
// Shared types and default sizing for the SCNN weight stream controller.
package scnn_wt_pkg;
  localparam int NUM_WTS_D = 25;
  localparam int DW_D      = 16;
  localparam int IW_D      = 8;
  localparam int NUM_PE_D  = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ARB,
    ST_STREAM
  } state_t;

  typedef struct packed {
    logic [DW_D-1:0] wt;
    logic [IW_D-1:0] ind;
  } pair_t;
endpackage

// File: rtl/scnn_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, priority rotates to the PE after the last winner.
module scnn_rr_arbiter #(
  parameter int NUM_PE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PE-1:0] i_req,
  input  logic              i_update,
  output logic [NUM_PE-1:0] o_grant
);
  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [PW-1:0] w_idx;
  logic          w_found;

  always_comb begin
    o_grant   = '0;
    w_ptr_nxt = r_ptr;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      w_idx = PW'((int'(r_ptr) + i) % NUM_PE);
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_ptr_nxt      = PW'((int'(w_idx) + 1) % NUM_PE);
        w_found        = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_update && w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end
endmodule

// File: rtl/scnn_wt_stream_ctrl.sv
// Zero-run compresses one filter into a pair buffer, then streams the pairs
// once to every PE in the captured mask, one destination at a time.
module scnn_wt_stream_ctrl
  import scnn_wt_pkg::*;
#(
  parameter int NUM_WTS = NUM_WTS_D,
  parameter int DW      = DW_D,
  parameter int IW      = IW_D,
  parameter int NUM_PE  = NUM_PE_D
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [NUM_WTS*DW-1:0] in_wts,
  input  logic [NUM_PE-1:0]     in_pe_mask,
  input  logic [NUM_PE-1:0]     pe_req,
  output logic [NUM_PE-1:0]     pe_grant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_wt,
  output logic [IW-1:0]         out_ind,
  output logic                  out_last,
  output logic [7:0]            nnz,
  output logic                  busy
);
  localparam int AW = $clog2(NUM_WTS);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DW-1:0]     r_wts [NUM_WTS];
  pair_t             r_buf [NUM_WTS];
  logic [NUM_PE-1:0] r_pending;
  logic [NUM_PE-1:0] r_grant;
  logic [AW-1:0]     r_scan_idx;
  logic [AW-1:0]     r_rd_ptr;
  logic [IW-1:0]     r_run;
  logic [7:0]        r_nnz;

  logic [DW-1:0]     w_cur_wt;
  logic              w_cur_nz;
  logic              w_accept;
  logic              w_scan_last;
  logic [NUM_PE-1:0] w_cand;
  logic [NUM_PE-1:0] w_arb_gnt;
  logic              w_arb_go;
  logic              w_beat_last;
  pair_t             w_rd_pair;

  assign w_cur_wt    = r_wts[r_scan_idx];
  assign w_cur_nz    = (w_cur_wt != '0);
  assign w_accept    = (r_state == ST_IDLE) && in_valid;
  assign w_scan_last = (r_scan_idx == AW'(NUM_WTS - 1));
  assign w_cand      = pe_req & r_pending;
  assign w_arb_go    = (r_state == ST_ARB) && (r_pending != '0) && (w_cand != '0);
  assign w_rd_pair   = r_buf[r_rd_ptr];
  // An empty filter still sends one terminating beat, so it is always "last".
  assign w_beat_last = (r_nnz == 8'd0) || (8'(r_rd_ptr) == r_nnz - 8'd1);

  scnn_rr_arbiter #(.NUM_PE(NUM_PE)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (w_cand),
    .i_update (w_arb_go),
    .o_grant  (w_arb_gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (in_valid) w_state_nxt = ST_SCAN;
      ST_SCAN:   if (w_scan_last) w_state_nxt = ST_ARB;
      ST_ARB: begin
        if (r_pending == '0)   w_state_nxt = ST_IDLE;
        else if (w_cand != '0) w_state_nxt = ST_STREAM;
      end
      ST_STREAM: if (out_ready && w_beat_last) w_state_nxt = ST_ARB;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_grant    <= '0;
      r_scan_idx <= '0;
      r_rd_ptr   <= '0;
      r_run      <= '0;
      r_nnz      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (in_valid) begin
          r_pending  <= in_pe_mask;
          r_nnz      <= '0;
          r_run      <= '0;
          r_scan_idx <= '0;
        end
        ST_SCAN: begin
          r_scan_idx <= r_scan_idx + 1'b1;
          if (w_cur_nz) begin
            r_nnz <= r_nnz + 8'd1;
            r_run <= '0;
          end else begin
            r_run <= r_run + 1'b1;
          end
        end
        ST_ARB: if (w_arb_go) begin
          r_grant  <= w_arb_gnt;
          r_rd_ptr <= '0;
        end
        ST_STREAM: if (out_ready) begin
          if (w_beat_last) begin
            r_pending <= r_pending & ~r_grant;
            r_grant   <= '0;
          end else begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Weight copy and pair buffer carry no reset; nnz gates every read.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int i = 0; i < NUM_WTS; i++) begin
        r_wts[i] <= in_wts[i*DW +: DW];
        r_buf[i] <= '0;
      end
    end else if (r_state == ST_SCAN && w_cur_nz) begin
      r_buf[r_nnz[AW-1:0]] <= '{wt: w_cur_wt, ind: r_run};
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign pe_grant  = r_grant;
  assign out_valid = (r_state == ST_STREAM);
  assign out_wt    = (out_valid && r_nnz != 8'd0) ? w_rd_pair.wt : '0;
  assign out_ind   = !out_valid ? '0 : ((r_nnz == 8'd0) ? IW'(NUM_WTS) : w_rd_pair.ind);
  assign out_last  = out_valid && w_beat_last;
  assign nnz       = r_nnz;
endmodule

// File: tb/tb_scnn_wt_stream_ctrl.sv
// Directed bench for scnn_wt_stream_ctrl with hand-computed expected beats.
module tb_scnn_wt_stream_ctrl;
  localparam int NUM_WTS = 25;
  localparam int DW      = 16;
  localparam int IW      = 8;
  localparam int NUM_PE  = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [NUM_WTS*DW-1:0] in_wts;
  logic [NUM_PE-1:0]     in_pe_mask;
  logic [NUM_PE-1:0]     pe_req;
  logic [NUM_PE-1:0]     pe_grant;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_wt;
  logic [IW-1:0]         out_ind;
  logic                  out_last;
  logic [7:0]            nnz;
  logic                  busy;

  int checks   = 0;
  int failures = 0;

  logic [NUM_WTS*DW-1:0] wts;
  logic [3:0]            order [3];
  int                    b;
  int                    n;
  logic                  rdy;
  logic                  seen;

  always #5 clk = ~clk;

  scnn_wt_stream_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wts     (in_wts),
    .in_pe_mask (in_pe_mask),
    .pe_req     (pe_req),
    .pe_grant   (pe_grant),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_wt     (out_wt),
    .out_ind    (out_ind),
    .out_last   (out_last),
    .nnz        (nnz),
    .busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input logic [3:0] g, input logic [15:0] wt,
                      input logic [7:0] ind, input logic last);
    chk({tag, ".vld"},   32'(out_valid), 32'd1);
    chk({tag, ".grant"}, 32'(pe_grant),  32'(g));
    chk({tag, ".wt"},    32'(out_wt),    32'(wt));
    chk({tag, ".ind"},   32'(out_ind),   32'(ind));
    chk({tag, ".last"},  32'(out_last),  32'(last));
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, ".in_ready"}, 32'(in_ready),  32'd1);
    chk({tag, ".busy"},     32'(busy),      32'd0);
    chk({tag, ".vld"},      32'(out_valid), 32'd0);
    chk({tag, ".grant"},    32'(pe_grant),  32'd0);
    chk({tag, ".wt"},       32'(out_wt),    32'd0);
    chk({tag, ".ind"},      32'(out_ind),   32'd0);
    chk({tag, ".last"},     32'(out_last),  32'd0);
    chk({tag, ".nnz"},      32'(nnz),       32'd0);
  endtask

  // Offer a filter; returns in the first SCAN cycle.
  task automatic load(input string tag, input logic [NUM_WTS*DW-1:0] w, input logic [3:0] m);
    in_wts     = w;
    in_pe_mask = m;
    in_valid   = 1'b1;
    chk({tag, ".rdy_idle"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk({tag, ".busy_scan"}, 32'(busy), 32'd1);
    chk({tag, ".rdy_scan"},  32'(in_ready), 32'd0);
  endtask

  // From the first SCAN cycle (T+1) to the ARB cycle (T+26).
  task automatic scan_to_arb(input string tag);
    repeat (NUM_WTS) step();
    chk({tag, ".arb_vld"},  32'(out_valid), 32'd0);
    chk({tag, ".arb_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_wts     = '0;
    in_pe_mask = '0;
    pe_req     = '0;
    out_ready  = 1'b1;
    order      = '{4'b1000, 4'b0001, 4'b0010};
    repeat (2) step();
    idle_outputs("reset");
    rst_n = 1'b1;
    step();
    idle_outputs("post_reset");

    // Sparse filter: pairs (5,0),(7,2),(9,20), first valid at T+27.
    wts = '0;
    wts[0*DW +: DW]  = 16'd5;
    wts[3*DW +: DW]  = 16'd7;
    wts[24*DW +: DW] = 16'd9;
    pe_req = 4'b0001;
    load("sparse", wts, 4'b0001);
    scan_to_arb("sparse");
    chk("sparse.nnz", 32'(nnz), 32'd3);
    step();
    beat("sparse.b0", 4'b0001, 16'd5, 8'd0, 1'b0);
    step();
    beat("sparse.b1", 4'b0001, 16'd7, 8'd2, 1'b0);
    step();
    beat("sparse.b2", 4'b0001, 16'd9, 8'd20, 1'b1);
    step();
    chk("sparse.arb_after_vld",   32'(out_valid), 32'd0);
    chk("sparse.arb_after_grant", 32'(pe_grant), 32'd0);
    step();
    chk("sparse.idle_rdy",  32'(in_ready), 32'd1);
    chk("sparse.idle_busy", 32'(busy), 32'd0);

    // All-zero filter to four PEs from a fresh round-robin pointer.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    pe_req = 4'b1111;
    load("zero", '0, 4'b1111);
    scan_to_arb("zero");
    chk("zero.nnz", 32'(nnz), 32'd0);
    for (int p = 0; p < 4; p++) begin
      step();
      beat("zero.beat", 4'(1 << p), 16'd0, 8'd25, 1'b1);
      step();
      chk("zero.arb_vld", 32'(out_valid), 32'd0);
    end
    step();
    chk("zero.idle_rdy", 32'(in_ready), 32'd1);

    // Round-robin: only PE2 requesting, then everyone.
    wts = '0;
    wts[0*DW +: DW] = 16'd3;
    pe_req = 4'b0100;
    load("rr", wts, 4'b1111);
    scan_to_arb("rr");
    step();
    beat("rr.first", 4'b0100, 16'd3, 8'd0, 1'b1);
    pe_req = 4'b1111;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("rr.arb_vld", 32'(out_valid), 32'd0);
      step();
      beat("rr.next", order[k], 16'd3, 8'd0, 1'b1);
    end
    step();
    step();
    chk("rr.idle_rdy", 32'(in_ready), 32'd1);

    // Dense filter 1..25 with out_ready toggling; stalled beats must hold.
    for (int i = 0; i < NUM_WTS; i++) wts[i*DW +: DW] = 16'(i + 1);
    pe_req = 4'b0001;
    load("dense", wts, 4'b0001);
    scan_to_arb("dense");
    chk("dense.nnz", 32'(nnz), 32'd25);
    step();
    b = 0;
    for (int c = 0; c < 60 && b < NUM_WTS; c++) begin
      beat("dense.beat", 4'b0001, 16'(b + 1), 8'd0, (b == NUM_WTS - 1));
      rdy       = (c % 2 == 1);
      out_ready = rdy;
      step();
      if (rdy) b++;
    end
    out_ready = 1'b1;
    chk("dense.beats_done", 32'(b), 32'd25);
    chk("dense.arb_vld", 32'(out_valid), 32'd0);
    step();
    chk("dense.idle_rdy", 32'(in_ready), 32'd1);

    // Empty mask: busy for SCAN + one ARB cycle, never valid.
    load("nomask", wts, 4'b0000);
    n    = 0;
    seen = 1'b0;
    while (busy === 1'b1 && n < 40) begin
      if (out_valid !== 1'b0) seen = 1'b1;
      n++;
      step();
    end
    chk("nomask.busy_cycles", 32'(n), 32'd26);
    chk("nomask.no_valid", 32'(seen), 32'd0);
    chk("nomask.idle_rdy", 32'(in_ready), 32'd1);

    // Asynchronous reset on the third beat aborts the stream.
    load("abort", wts, 4'b0001);
    scan_to_arb("abort");
    step();
    beat("abort.b0", 4'b0001, 16'd1, 8'd0, 1'b0);
    step();
    beat("abort.b1", 4'b0001, 16'd2, 8'd0, 1'b0);
    step();
    beat("abort.b2", 4'b0001, 16'd3, 8'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    idle_outputs("abort.reset");
    step();
    rst_n = 1'b1;
    step();
    wts = '0;
    wts[0*DW +: DW]  = 16'd5;
    wts[3*DW +: DW]  = 16'd7;
    wts[24*DW +: DW] = 16'd9;
    load("restart", wts, 4'b0001);
    scan_to_arb("restart");
    step();
    beat("restart.b0", 4'b0001, 16'd5, 8'd0, 1'b0);
    step();
    beat("restart.b1", 4'b0001, 16'd7, 8'd2, 1'b0);
    step();
    beat("restart.b2", 4'b0001, 16'd9, 8'd20, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench did not finish in time");
  end
endmodule
